// File: rtl/incr_pkg.sv
// Shared constants and helpers for the round-robin incrementer arbiter.
package incr_pkg;
    localparam int DATA_W = 4;
    localparam logic [DATA_W-1:0] OVF_OPERAND = 4'hF;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/incrementor_4bit.sv
// The single shared 4-bit incrementer; wraps modulo 16.
module incrementor_4bit (
    input  logic [3:0] a_i,
    output logic [3:0] y_o
);
    assign y_o = a_i + 4'd1;
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/incr_rr_arbiter.sv
// Shares one incrementer among NUM_REQ requesters with round-robin grant and
// a single registered output stage under valid/ready backpressure.
module incr_rr_arbiter
    import incr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_ovf,
    output logic [IDX_W-1:0]            rsp_id,
    input  logic                        rsp_ready
);
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_ovf_q;
    logic [IDX_W-1:0]   rsp_id_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               adv, fire;
    logic [DATA_W-1:0]  operand, sum;

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Gating with rst_n keeps grants quiet during reset, as the request is
    // consumed combinationally by the requester.
    assign adv  = !rsp_valid_q || rsp_ready;
    assign fire = adv && pick_any && rst_n;
    assign gnt  = fire ? pick_gnt : '0;

    assign operand = req_data[pick_idx*DATA_W +: DATA_W];

    incrementor_4bit u_inc (
        .a_i (operand),
        .y_o (sum)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (fire)
            ptr_d = (int'(pick_idx) == NUM_REQ-1) ? '0 : pick_idx + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (fire) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= sum;
                rsp_ovf_q   <= (operand == OVF_OPERAND);
                rsp_id_q    <= pick_idx;
            end else if (adv) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_incr_rr_arbiter.sv
// Directed and randomized checks of incr_rr_arbiter against a behavioural model.
module tb_incr_rr_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [4*N-1:0] req_data = '0;
    logic [N-1:0]  gnt;
    logic          rsp_valid;
    logic [3:0]    rsp_data;
    logic          rsp_ovf;
    logic [1:0]    rsp_id;
    logic          rsp_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_ptr;
    bit m_valid;
    int m_data, m_id;
    bit m_ovf;

    incr_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // winner index by the round-robin rule, -1 when no grant
    function automatic int model_winner();
        if (!rst_n) return -1;
        if (!(!m_valid || rsp_ready)) return -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0;
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic [4*N-1:0] d, input logic rdy,
                       output logic [N-1:0] g);
        int w, op;
        logic [N-1:0] eg;
        @(negedge clk);
        req = r; req_data = d; rsp_ready = rdy;
        #1;
        w  = model_winner();
        eg = (w < 0) ? '0 : (N'(1) << w);
        g  = gnt;
        chk("gnt", gnt, eg);
        chk("valid", rsp_valid, m_valid);
        if (m_valid) begin
            chk("data", rsp_data, m_data);
            chk("id", rsp_id, m_id);
            chk("ovf", rsp_ovf, m_ovf);
        end
        @(posedge clk);
        if (w >= 0) begin
            op      = (d >> (4*w)) & 15;
            m_data  = (op + 1) % 16;
            m_ovf   = (op == 15);
            m_id    = w;
            m_valid = 1;
            m_ptr   = (w + 1) % N;
        end else if (!m_valid || rdy) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_ovf", rsp_ovf, 0);
        chk("rst_id", rsp_id, 0);
        req = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", gnt, 0);
        chk("post_rst_valid", rsp_valid, 0);
    endtask

    initial begin
        logic [N-1:0] g, pr, pg, r;
        logic [4*N-1:0] d;
        logic [N-1:0] rr_exp [5];
        int rr_dat [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dat = '{2, 3, 4, 5, 2};

        model_reset();
        do_reset();

        // single request
        cyc(4'b0100, 16'h0700, 1'b1, g);
        chk("single_gnt", g, 4'b0100);
        chk("single_valid", rsp_valid, 1);
        chk("single_data", rsp_data, 4'h8);
        chk("single_id", rsp_id, 2);
        chk("single_ovf", rsp_ovf, 0);
        cyc(4'b0000, 16'h0000, 1'b1, g);
        chk("idle_valid", rsp_valid, 0);

        // wrap
        cyc(4'b0001, 16'h000F, 1'b1, g);
        chk("wrap_data", rsp_data, 4'h0);
        chk("wrap_ovf", rsp_ovf, 1);

        // round robin
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 16'h4321, 1'b1, g);
            chk("rr_gnt", g, rr_exp[i]);
            chk("rr_data", rsp_data, rr_dat[i]);
        end

        // backpressure
        do_reset();
        cyc(4'b0001, 16'h0035, 1'b0, g);
        chk("bp_first_gnt", g, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0011, 16'h0035, 1'b0, g);
            chk("bp_stall_gnt", g, 4'b0000);
            chk("bp_hold_data", rsp_data, 4'h6);
            chk("bp_hold_id", rsp_id, 0);
        end
        cyc(4'b0011, 16'h0035, 1'b1, g);
        chk("bp_release_gnt", g, 4'b0010);
        chk("bp_release_data", rsp_data, 4'h4);
        chk("bp_release_id", rsp_id, 1);

        // pointer skip
        do_reset();
        cyc(4'b0010, 16'h0000, 1'b1, g);
        cyc(4'b0001, 16'h0009, 1'b1, g);
        chk("skip_gnt0", g, 4'b0001);
        cyc(4'b0011, 16'h0000, 1'b1, g);
        chk("skip_gnt1", g, 4'b0010);

        // reset with a pending result and live requests
        cyc(4'b1111, 16'h1111, 1'b0, g);
        req = 4'b1111;
        do_reset();

        // randomized, honouring the hold-until-granted rule
        pr = '0; pg = '0; d = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pr[i] && !pg[i]) begin
                    r[i] = ($urandom_range(9, 0) != 0);
                end else begin
                    r[i] = $urandom_range(1, 0);
                    d[4*i +: 4] = 4'($urandom_range(15, 0));
                end
            end
            cyc(r, d, 1'($urandom_range(3, 0) != 0), g);
            pr = r; pg = g;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/incr_rr_arbiter.md
Name: incr_rr_arbiter

Overview:
- Shares one 4-bit incrementer datapath among NUM_REQ requesters.
- Round-robin arbitration; one operand accepted per cycle at most.
- Result is registered in a single output stage with valid/ready backpressure.
- Sits between requester blocks (counters, address generators) and the single incrementer instance, so only one adder is built.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of the requester index (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held with its operand until granted.
- req_data  in  NUM_REQ*4  packed operands; requester i occupies bits [4i+3:4i].
- gnt  out  NUM_REQ  one-hot grant, combinational; the request is consumed in the cycle gnt[i] is high.
- rsp_valid  out  1  output register holds a result.
- rsp_data  out  4  registered result, operand+1 mod 16.
- rsp_ovf  out  1  operand was 4'hF, so the result wrapped to 0.
- rsp_id  out  IDX_W  index of the requester that owns the result.
- rsp_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_id=0.
  - Round-robin pointer = 0 (requester 0 has highest priority).
  - gnt=0 while rst_n is low.
- Advance condition: adv = !rsp_valid || rsp_ready.
- Grant:
  - When adv=1 and req!=0, exactly one gnt bit goes high.
  - Winner = first requester with req high, searching from the pointer upward with wrap-around.
  - When adv=0, gnt=0 regardless of req (stall).
- Pointer: on a grant to index k, the pointer becomes (k+1) mod NUM_REQ. It is unchanged when there is no grant.
- Datapath:
  - The granted operand drives the incrementer input combinationally.
  - On the clock edge of the grant cycle: rsp_data <= incrementer output; rsp_ovf <= (operand==4'hF); rsp_id <= k; rsp_valid <= 1.
  - Latency: one cycle from grant to rsp_valid.
- Output stage:
  - If adv=1 and there is no grant, rsp_valid <= 0.
  - rsp_data, rsp_ovf and rsp_id hold their values while rsp_valid=1 and rsp_ready=0.
  - rsp_valid=1 with rsp_ready=1 and a new grant in the same cycle gives back-to-back results, sustaining one result per cycle.
- Arithmetic: 4-bit, modulo 16. 4'hF -> 4'h0 with ovf=1; every other value gives +1 with ovf=0.
- Fairness: with all requesters continuously asserting and rsp_ready=1, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- Requester obligations: a requester must not change req_data while req is high and ungranted. Dropping req before grant is legal; no grant is then issued to it.
- Reset mid-operation: a pending result is discarded (rsp_valid=0). No stale grant follows reset release.
- rsp_ready is ignored when rsp_valid=0.

Decomposition:
- Shared package incr_pkg:
  - DATA_W=4.
  - Localparam function for the index width.
  - Constant for the overflow operand (4'hF).
- Sub-modules:
  - The existing 4-bit incrementer (incrementor_4bit) is instantiated once as the datapath sub-module; overflow is computed in this block from the operand.
  - Arbitration (pointer plus masked priority search) may be split into rr_pick, combinational plus the pointer register. This split is optional; keeping it in-line is acceptable.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with rsp_valid=1 -> rsp_valid=0, gnt=0 immediately; after release with req=0, outputs stay 0.
- Single request: req=4'b0100, data[2]=4'h7, rsp_ready=1 -> gnt=4'b0100 in cycle 0; in cycle 1 rsp_valid=1, rsp_data=4'h8, rsp_id=2, rsp_ovf=0.
- Wrap: req[0]=1 with operand 4'hF -> rsp_data=4'h0, rsp_ovf=1.
- Round robin: req=4'b1111 held, operands 1,2,3,4, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_data sequence 2,3,4,5,2 one cycle later.
- Backpressure: result pending, rsp_ready=0 for 3 cycles with req=4'b0011 -> gnt=0, rsp_data/rsp_id stable; on rsp_ready=1, a grant is issued the same cycle and the new result appears next cycle.
- Pointer skip: pointer=2, req=4'b0001 -> grant to 0; pointer becomes 1; next req=4'b0011 -> grant 1.
